// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer upstream of the PC: fetches pc_out over req/ack, holds the
// instruction for the datapath, resolves Hack jump conditions and drives the PC controls.
module fetch_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pc_out,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_data,
    output logic [15:0]        instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic [15:0]        a_reg,
    input  logic               zr,
    input  logic               ng,
    input  logic               halt,
    output logic [1:0]         pc_ctrl,
    output logic [15:0]        pc_in,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_imem_req;
    logic [15:0]        r_imem_addr;
    logic [15:0]        r_instr;
    logic               r_instr_valid;
    logic [1:0]         r_pc_ctrl;
    logic [15:0]        r_pc_in;
    logic               r_halted;
    logic               r_fault;
    logic [COUNT_W-1:0] r_instr_count;

    logic [2:0]  w_next;
    logic        w_take;
    logic [15:0] w_upd_addr;

    assign w_take = r_instr[15] & ((r_instr[2] & ng) | (r_instr[1] & zr) |
                                   (r_instr[0] & ~ng & ~zr));

    // Leaving UPDATE, pc_out has not yet moved, so fetch where the PC is about to land.
    assign w_upd_addr = (r_pc_ctrl == 2'b10) ? r_pc_in : pc_out + 16'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack)
                    w_next = S_EXEC;
                else if (r_to_cnt == TO_LAST)
                    w_next = S_FAULT;
            end
            S_EXEC:   if (exec_done) w_next = S_UPDATE;
            S_UPDATE: w_next = halt ? S_HALT : S_FETCH;
            S_HALT:   if (!halt) w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_ctrl     <= 2'b00;
            r_pc_in       <= '0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_next;
            r_imem_req    <= (w_next == S_FETCH);
            r_instr_valid <= (w_next == S_EXEC);
            r_halted      <= (w_next == S_HALT);
            r_pc_ctrl     <= 2'b00;

            if (w_next == S_FETCH && r_state != S_FETCH)
                r_imem_addr <= (r_state == S_UPDATE) ? w_upd_addr : pc_out;

            if (r_state == S_FETCH && !imem_ack)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;

            if (r_state == S_FETCH && imem_ack)
                r_instr <= imem_data;

            if (r_state == S_EXEC && exec_done) begin
                r_pc_ctrl     <= w_take ? 2'b10 : 2'b01;
                r_instr_count <= r_instr_count + COUNT_W'(1);
                if (w_take)
                    r_pc_in <= a_reg;
            end

            if (w_next == S_FAULT)
                r_fault <= 1'b1;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_ctrl     = r_pc_ctrl;
    assign pc_in       = r_pc_in;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: the bench owns the PC and instruction memory and predicts
// each instruction's outcome from the jump semantics (jump if ALU result <0 / ==0 / >0).
module tb_fetch_ctrl;

    localparam int TIMEOUT = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        pc_out = 16'h0000;
    logic               imem_req;
    logic [15:0]        imem_addr;
    logic               imem_ack = 1'b0;
    logic [15:0]        imem_data = 16'h0000;
    logic [15:0]        instr;
    logic               instr_valid;
    logic               exec_done = 1'b0;
    logic [15:0]        a_reg = 16'h0000;
    logic               zr = 1'b0;
    logic               ng = 1'b0;
    logic               halt = 1'b0;
    logic [1:0]         pc_ctrl;
    logic [15:0]        pc_in;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]        m_pc   = 16'h0000;
    logic [15:0]        m_pcin = 16'h0000;
    logic [COUNT_W-1:0] m_cnt  = '0;

    fetch_ctrl #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
        .a_reg(a_reg), .zr(zr), .ng(ng), .halt(halt),
        .pc_ctrl(pc_ctrl), .pc_in(pc_in), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Program counter block driven by the sequencer; deliberately not reset by rst.
    always @(posedge clk) begin
        if (pc_ctrl == 2'b01)
            pc_out <= pc_out + 16'd1;
        else if (pc_ctrl == 2'b10)
            pc_out <= pc_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_req",   {31'd0, imem_req},    0);
        chk("rst_addr",  {16'd0, imem_addr},   0);
        chk("rst_instr", {16'd0, instr},       0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_pcc",   {30'd0, pc_ctrl},     0);
        chk("rst_pcin",  {16'd0, pc_in},       0);
        chk("rst_halt",  {31'd0, halted},      0);
        chk("rst_fault", {31'd0, fault},       0);
        chk("rst_cnt",   32'(instr_count),     0);
    endtask

    task automatic rand_side();
        zr    = 1'($urandom);
        ng    = 1'($urandom);
        a_reg = 16'($urandom);
        halt  = 1'($urandom);
    endtask

    // Called at a falling edge while the DUT is in its first FETCH cycle; returns likewise.
    task automatic run_instr(input logic [15:0] iw, input int ack_dly, input int ex_dly,
                             input logic signed [15:0] alu, input logic [15:0] areg,
                             input logic hlt);
        logic taken;
        taken = iw[15] && ((iw[2] && alu < 0) || (iw[1] && alu == 0) || (iw[0] && alu > 0));
        for (int i = 0; i <= ack_dly; i++) begin
            chk("fetch_req",   {31'd0, imem_req}, 1);
            chk("fetch_addr",  {16'd0, imem_addr}, {16'd0, m_pc});
            chk("fetch_fault", {31'd0, fault}, 0);
            chk("fetch_pcc",   {30'd0, pc_ctrl}, 0);
            rand_side();
            exec_done = 1'($urandom);
            imem_ack  = (i == ack_dly);
            imem_data = (i == ack_dly) ? iw : 16'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i <= ex_dly; i++) begin
            chk("exec_valid", {31'd0, instr_valid}, 1);
            chk("exec_instr", {16'd0, instr}, {16'd0, iw});
            chk("exec_req",   {31'd0, imem_req}, 0);
            chk("exec_pcc",   {30'd0, pc_ctrl}, 0);
            rand_side();
            imem_ack  = 1'($urandom);
            imem_data = 16'($urandom);
            exec_done = (i == ex_dly);
            if (i == ex_dly) begin
                zr    = (alu == 0);
                ng    = (alu < 0);
                a_reg = areg;
            end
            @(negedge clk);
        end
        m_cnt = m_cnt + 1'b1;
        if (taken)
            m_pcin = areg;
        chk("upd_pcc",   {30'd0, pc_ctrl}, taken ? 32'd2 : 32'd1);
        chk("upd_pcin",  {16'd0, pc_in}, {16'd0, m_pcin});
        chk("upd_cnt",   32'(instr_count), 32'(m_cnt));
        chk("upd_valid", {31'd0, instr_valid}, 0);
        m_pc      = taken ? areg : m_pc + 16'd1;
        halt      = hlt;
        exec_done = 1'($urandom);
        imem_ack  = 1'($urandom);
        @(negedge clk);
        chk("post_pcc", {30'd0, pc_ctrl}, 0);
        if (hlt) begin
            for (int i = 0; i < 3; i++) begin
                chk("halt_flag", {31'd0, halted}, 1);
                chk("halt_req",  {31'd0, imem_req}, 0);
                chk("halt_pcc",  {30'd0, pc_ctrl}, 0);
                halt      = (i < 2);
                imem_ack  = 1'($urandom);
                exec_done = 1'($urandom);
                @(negedge clk);
            end
        end
        chk("run_halted", {31'd0, halted}, 0);
        imem_ack  = 1'b0;
        exec_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero();
        rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 0);
        @(negedge clk);

        // Directed program: plain A-instruction, unconditional jump, JEQ not taken.
        run_instr(16'h0005, 0, 0, 16'sd7, 16'h1111, 1'b0);
        run_instr(16'hEA87, 0, 0, 16'sd0, 16'h0040, 1'b0);
        run_instr(16'hE302, 0, 0, 16'sd3, 16'h2222, 1'b0);

        // Asynchronous reset in the middle of EXEC with three instructions retired.
        chk("pre_rst_addr", {16'd0, imem_addr}, {16'd0, m_pc});
        imem_ack  = 1'b1;
        imem_data = 16'h1234;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 1);
        chk("pre_rst_cnt",   32'(instr_count), 3);
        #2 rst = 1'b1;
        #1 chk_all_zero();
        @(negedge clk);
        rst    = 1'b0;
        m_cnt  = '0;
        m_pcin = 16'h0000;
        @(negedge clk);

        run_instr(16'hE302, 5, 0, 16'sd0,  16'h0100, 1'b0);
        run_instr(16'hE301, 0, 2, 16'sd9,  16'h0200, 1'b0);
        run_instr(16'hE304, 0, 0, 16'sd9,  16'h0300, 1'b0);
        run_instr(16'hE304, 1, 1, -16'sd4, 16'h0400, 1'b1);
        run_instr(16'h0000, 0, 0, -16'sd1, 16'hFFFF, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] iw;
            logic signed [15:0] alu;
            iw  = 16'($urandom);
            alu = ($urandom_range(0, 3) == 0) ? 16'sd0 : 16'($urandom);
            run_instr(iw, $urandom_range(0, 6), $urandom_range(0, 3), alu,
                      16'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Fetch that never completes: FAULT after TIMEOUT cycles, then absorbing.
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_req",   {31'd0, imem_req}, 1);
            chk("to_fault", {31'd0, fault}, 0);
            imem_ack  = 1'b0;
            exec_done = 1'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk("fault_flag", {31'd0, fault}, 1);
            chk("fault_req",  {31'd0, imem_req}, 0);
            chk("fault_pcc",  {30'd0, pc_ctrl}, 0);
            imem_ack  = 1'b1;
            imem_data = 16'($urandom);
            exec_done = 1'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_req",  {31'd0, imem_req}, 1);
        chk("restart_addr", {16'd0, imem_addr}, {16'd0, m_pc});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
